drum_step_sequencer: RTL and testbench
======================================

// Module: drum_step_sequencer
// PURPOSE
//  Step sequencer for the tone (sine) and noise voices. Walks a 16-entry pattern
//  at a programmable tempo. Per step it gates each voice and loads the tone clock
//  divider's stop value (pitch). Sits between the control switches/host and the
//  clock-divider/sine/noise datapath; it is the only writer of the divider period.
// PARAMETERS
//  STEPS        16     pattern length; step_idx wraps STEPS-1 -> 0
//  TEMPO_W      24     width of tempo_div / tempo counter
//  GATE_W       16     width of gate_len
//  DIV_W        32     width of tone_stop (divider stop value)
//  BASE_STOP    100    tone_stop for pitch index 0
//  PITCH_SHIFT  4      tone_stop = BASE_STOP + (pitch << PITCH_SHIFT), truncated to DIV_W
// PORTS
//  clk        in   1        system clock
//  reset      in   1        asynchronous, active-high
//  run        in   1        1 = play; 0 = stop after the current step completes
//  tempo_div  in   TEMPO_W  PLAY length per step minus 1 (cycles)
//  gate_len   in   GATE_W   gate-high cycles per step
//  pat_we     in   1        pattern write strobe
//  pat_addr   in   4        pattern write address
//  pat_data   in   8        [7]=noise hit, [6]=tone hit, [5:0]=pitch index
//  step_idx   out  4        step currently playing
//  step_tick  out  1        1-cycle pulse on the first PLAY cycle of each step
//  tone_gate  out  1        enables sine voice
//  noise_gate out  1        enables noise voice
//  tone_stop  out  DIV_W    stop value for tone clock divider
//  busy       out  1        high in LOAD/PLAY
// BEHAVIOUR
//  Reset: all outputs 0 except tone_stop=BASE_STOP; state IDLE; tcnt=0;
//   all pattern entries cleared to 0. Reset mid-step aborts immediately.
//  All outputs registered. Pattern writes take effect at the posedge after pat_we=1.
//  FSM:
//   IDLE : gates 0, busy 0, step_idx 0. run=1 -> LOAD.
//   LOAD : 1 cycle. Latch entry=pattern[step_idx], tempo_div and gate_len
//          (mid-step input changes apply next step). Latch
//          tone_stop=BASE_STOP+(pitch<<PITCH_SHIFT). tcnt<=0. -> PLAY.
//   PLAY : tcnt+1 per cycle.
//          step_tick=1 iff tcnt==0.
//          tone_gate=entry[6]&&(tcnt<gate_len); noise_gate=entry[7]&&(tcnt<gate_len).
//          At tcnt==tempo_div: run=1 -> step_idx+1 (wrap at STEPS-1), LOAD;
//          run=0 -> step_idx<=0, IDLE.
//  Step period = tempo_div+2 cycles (1 LOAD + tempo_div+1 PLAY); gates 0 during LOAD.
//  run only sampled in IDLE and at end of PLAY; a drop mid-step never truncates a gate.
//  gate_len=0: no gate. gate_len>tempo_div: gate high for all PLAY cycles.
//  tempo_div=0: PLAY lasts 1 cycle.
//  Write to the entry LOAD is latching in the same cycle: LOAD gets the old value.
//  tone_stop holds its last value in IDLE.
// CONFIGURATION
//  DRUM_SEQ_SWING_EN defined: adds input swing_amt [TEMPO_W-1:0], latched in LOAD.
//   On odd step_idx the PLAY end condition becomes tcnt==tempo_div+swing_amt
//   (TEMPO_W+1-bit compare, no wrap).
//  Undefined: no swing_amt port; all steps are equal length.
// TESTING
//  1 Assert reset -> step_idx=0, gates=0, step_tick=0, busy=0, tone_stop=100; pattern reads 0.
//  2 pattern[0]=8'hC3, tempo_div=9, gate_len=4, run=1 -> step_tick once; both
//    gates high 4 cycles; tone_stop=148; next step_tick 11 cycles later.
//  3 run held, tempo_div=0 -> step_idx 0..15,0 with ticks every 2 cycles;
//    the pattern entry of each step is applied.
//  4 Drop run at tcnt=3 of step 5 (gate_len=8, tempo_div=9) -> gate stays high
//    through tcnt=7; IDLE after tcnt=9; step_idx=0, busy=0.
//  5 gate_len=0 -> gates never rise; gate_len=20, tempo_div=9 -> gate high
//    10 cycles, low 1 cycle (LOAD), repeating.
//  6 SWING_EN, swing_amt=3, tempo_div=9 -> even steps 11 cycles, odd steps 14 cycles.

Source files
------------

// File: rtl/drum_step_sequencer.sv
// Drum step sequencer: walks a 16-entry pattern at a programmable tempo, gating the
// tone/noise voices and loading the tone divider stop value. Option: DRUM_SEQ_SWING_EN.
module drum_step_sequencer #(
  parameter int unsigned STEPS       = 16,
  parameter int unsigned TEMPO_W     = 24,
  parameter int unsigned GATE_W      = 16,
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned BASE_STOP   = 100,
  parameter int unsigned PITCH_SHIFT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [TEMPO_W-1:0] tempo_div,
  input  logic [GATE_W-1:0]  gate_len,
  input  logic               pat_we,
  input  logic [3:0]         pat_addr,
  input  logic [7:0]         pat_data,
  output logic [3:0]         step_idx,
  output logic               step_tick,
  output logic               tone_gate,
  output logic               noise_gate,
  output logic [DIV_W-1:0]   tone_stop,
  output logic               busy
`ifdef DRUM_SEQ_SWING_EN
  ,
  input  logic [TEMPO_W-1:0] swing_amt
`endif
);

  localparam int unsigned CNT_W = TEMPO_W + 1;
  localparam int unsigned CMP_W = (CNT_W > GATE_W) ? CNT_W : GATE_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY
  } state_t;

  state_t             state;
  logic [7:0]         pattern [16];
  logic [CNT_W-1:0]   tcnt;
  logic [TEMPO_W-1:0] tempo_lat;
  logic [GATE_W-1:0]  gate_lat;
  logic               ent_tone;
  logic               ent_noise;

`ifdef DRUM_SEQ_SWING_EN
  logic [TEMPO_W-1:0] swing_lat;
`endif

  logic [CNT_W-1:0]   end_cnt;
  logic [CMP_W-1:0]   next_cnt;
  logic               next_in_gate;
  logic               load_in_gate;
  logic [7:0]         load_entry;
  logic [DIV_W-1:0]   load_stop;
  logic [3:0]         next_idx;

  always_comb begin
    end_cnt = {1'b0, tempo_lat};
`ifdef DRUM_SEQ_SWING_EN
    // Swing stretches odd steps; one extra bit keeps the sum from wrapping.
    if (step_idx[0]) end_cnt = {1'b0, tempo_lat} + {1'b0, swing_lat};
`endif
    next_cnt     = CMP_W'(tcnt) + CMP_W'(1);
    next_in_gate = next_cnt < CMP_W'(gate_lat);
    load_entry   = pattern[step_idx];
    load_in_gate = (gate_len != '0);
    load_stop    = DIV_W'(BASE_STOP) + (DIV_W'(load_entry[5:0]) << PITCH_SHIFT);
    next_idx     = (step_idx == 4'(STEPS - 1)) ? '0 : step_idx + 4'd1;
  end

  // Outputs are computed for the state being entered so they line up with tcnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      tempo_lat  <= '0;
      gate_lat   <= '0;
      ent_tone   <= 1'b0;
      ent_noise  <= 1'b0;
`ifdef DRUM_SEQ_SWING_EN
      swing_lat  <= '0;
`endif
      step_idx   <= '0;
      step_tick  <= 1'b0;
      tone_gate  <= 1'b0;
      noise_gate <= 1'b0;
      tone_stop  <= DIV_W'(BASE_STOP);
      busy       <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) pattern[i] <= '0;
    end else begin
      if (pat_we) pattern[pat_addr] <= pat_data;

      case (state)
        S_IDLE: begin
          step_idx   <= '0;
          step_tick  <= 1'b0;
          tone_gate  <= 1'b0;
          noise_gate <= 1'b0;
          if (run) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end

        S_LOAD: begin
          ent_tone   <= load_entry[6];
          ent_noise  <= load_entry[7];
          tempo_lat  <= tempo_div;
          gate_lat   <= gate_len;
`ifdef DRUM_SEQ_SWING_EN
          swing_lat  <= swing_amt;
`endif
          tone_stop  <= load_stop;
          tcnt       <= '0;
          state      <= S_PLAY;
          busy       <= 1'b1;
          step_tick  <= 1'b1;
          tone_gate  <= load_entry[6] && load_in_gate;
          noise_gate <= load_entry[7] && load_in_gate;
        end

        S_PLAY: begin
          step_tick <= 1'b0;
          if (tcnt == end_cnt) begin
            tone_gate  <= 1'b0;
            noise_gate <= 1'b0;
            if (run) begin
              step_idx <= next_idx;
              state    <= S_LOAD;
              busy     <= 1'b1;
            end else begin
              step_idx <= '0;
              state    <= S_IDLE;
              busy     <= 1'b0;
            end
          end else begin
            tcnt       <= tcnt + CNT_W'(1);
            tone_gate  <= ent_tone && next_in_gate;
            noise_gate <= ent_noise && next_in_gate;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Scoreboard bench for drum_step_sequencer: stimulus queues expected steps, a monitor
// checks each step at its step_tick and measures its length and gate-high cycles.
module tb_drum_step_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [23:0] tempo_div = '0;
  logic [15:0] gate_len = '0;
  logic        pat_we = 1'b0;
  logic [3:0]  pat_addr = '0;
  logic [7:0]  pat_data = '0;
  logic [3:0]  step_idx;
  logic        step_tick;
  logic        tone_gate;
  logic        noise_gate;
  logic [31:0] tone_stop;
  logic        busy;
`ifdef DRUM_SEQ_SWING_EN
  logic [23:0] swing_amt = '0;
`endif

  always #5 clk = ~clk;

  drum_step_sequencer #(
    .STEPS(16), .TEMPO_W(24), .GATE_W(16), .DIV_W(32), .BASE_STOP(100), .PITCH_SHIFT(4)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .tempo_div(tempo_div), .gate_len(gate_len),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
    .step_idx(step_idx), .step_tick(step_tick), .tone_gate(tone_gate),
    .noise_gate(noise_gate), .tone_stop(tone_stop), .busy(busy)
`ifdef DRUM_SEQ_SWING_EN
    , .swing_amt(swing_amt)
`endif
  );

  typedef struct {
    logic [3:0]  idx;
    logic        tone;
    logic        noise;
    logic [31:0] stop;
    int unsigned len;
    int unsigned thi;
    int unsigned nhi;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          total = 0;
  int          bad = 0;
  int unsigned tick_count = 0;
  logic [7:0]  pat_model [16];
  bit          open = 1'b0;
  int unsigned cyc, th, nh;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void close_step();
    check("step_len", cyc, cur.len);
    check("tone_high_cycles", th, cur.thi);
    check("noise_high_cycles", nh, cur.nhi);
  endfunction

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        open = 1'b0;
      end else begin
        if (step_tick) begin
          if (open) close_step();
          check("tick_expected", 32'(q.size() > 0), 1);
          if (q.size() > 0) begin
            cur = q.pop_front();
            check("tick_step_idx", step_idx, cur.idx);
            check("tick_tone_gate", tone_gate, cur.tone);
            check("tick_noise_gate", noise_gate, cur.noise);
            check("tick_tone_stop", tone_stop, cur.stop);
            open = 1'b1;
            cyc = 0; th = 0; nh = 0;
          end else begin
            open = 1'b0;
          end
          tick_count++;
        end else if (open && !busy) begin
          close_step();
          check("idle_step_idx", step_idx, 0);
          open = 1'b0;
        end
        if (open) begin
          cyc++;
          th += tone_gate;
          nh += noise_gate;
        end
      end
    end
  end

  task automatic write_pat(input int unsigned a, input logic [7:0] d);
    @(negedge clk);
    pat_we = 1'b1; pat_addr = 4'(a); pat_data = d;
    @(negedge clk);
    pat_we = 1'b0;
    pat_model[a] = d;
  endtask

  task automatic push_steps(input int unsigned n, input int unsigned tempo,
                            input int unsigned gate, input int unsigned swing);
    exp_t x;
    logic [7:0] e;
    int unsigned idx, per;
    for (int unsigned k = 0; k < n; k++) begin
      idx = k % 16;
      e = pat_model[idx];
      per = tempo + 1 + ((idx % 2 == 1) ? swing : 0);
      x.idx = 4'(idx);
      x.tone = e[6] && (gate > 0);
      x.noise = e[7] && (gate > 0);
      x.stop = 100 + 32'(e[5:0]) * 16;
      x.len = per + ((k + 1 < n) ? 1 : 0);
      x.thi = e[6] ? ((gate < per) ? gate : per) : 0;
      x.nhi = e[7] ? ((gate < per) ? gate : per) : 0;
      q.push_back(x);
    end
  endtask

  task automatic wait_ticks(input int unsigned target);
    bit ok = 1'b0;
    for (int unsigned i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk); #1;
      if (tick_count >= target) ok = 1'b1;
    end
    check("wait_tick_reached", 32'(ok), 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int unsigned i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk); #1;
      if (!busy && !open && q.size() == 0) ok = 1'b1;
    end
    check("wait_idle_reached", 32'(ok), 1);
  endtask

  task automatic set_swing(input int unsigned s);
`ifdef DRUM_SEQ_SWING_EN
    swing_amt = 24'(s);
`else
    if (s != 0) $display("swing ignored");
`endif
  endtask

  task automatic play(input int unsigned n, input int unsigned tempo,
                      input int unsigned gate, input int unsigned swing);
    int unsigned base;
    tempo_div = 24'(tempo); gate_len = 16'(gate); set_swing(swing);
    push_steps(n, tempo, gate, swing);
    base = tick_count;
    @(negedge clk); #1;
    run = 1'b1;
    wait_ticks(base + n);
    run = 1'b0;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    for (int i = 0; i < 16; i++) pat_model[i] = '0;

    repeat (2) @(negedge clk);
    check("reset_step_idx", step_idx, 0);
    check("reset_step_tick", step_tick, 0);
    check("reset_tone_gate", tone_gate, 0);
    check("reset_noise_gate", noise_gate, 0);
    check("reset_busy", busy, 0);
    check("reset_tone_stop", tone_stop, 100);
    reset = 1'b0;

    // Untouched pattern plays as a silent step at the base pitch
    play(1, 2, 4, 0);

    // Two steps at tempo 9: noise+tone pitch 3, then tone-only pitch 5
    write_pat(0, 8'hC3);
    write_pat(1, 8'h45);
    play(2, 9, 4, 0);
    check("idle_holds_tone_stop", tone_stop, 180);

    // Full pattern wrap at tempo 0
    for (int unsigned i = 0; i < 16; i++)
      write_pat(i, {(i % 3 != 1) ? 1'b1 : 1'b0, (i % 4 != 3) ? 1'b1 : 1'b0, 6'(i * 3 + 1)});
    play(17, 0, 1, 0);

    // Drop run at tcnt=3 of step 5: gate must still last 8 cycles
    tempo_div = 24'd9; gate_len = 16'd8; set_swing(0);
    push_steps(6, 9, 8, 0);
    base = tick_count;
    @(negedge clk); #1;
    run = 1'b1;
    wait_ticks(base + 6);
    repeat (3) @(negedge clk);
    #1 run = 1'b0;
    wait_idle();
    check("stop_busy_low", busy, 0);
    check("stop_step_idx", step_idx, 0);

    // gate_len boundaries
    play(3, 3, 0, 0);
    play(3, 9, 20, 0);

`ifdef DRUM_SEQ_SWING_EN
    play(4, 9, 4, 3);
`endif

    // Reset in mid-step aborts and clears the pattern
    tempo_div = 24'd9; gate_len = 16'd8; set_swing(0);
    push_steps(1, 9, 8, 0);
    base = tick_count;
    @(negedge clk); #1;
    run = 1'b1;
    wait_ticks(base + 1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_tone_gate", tone_gate, 0);
    check("abort_noise_gate", noise_gate, 0);
    check("abort_tone_stop", tone_stop, 100);
    run = 1'b0;
    q.delete();
    for (int i = 0; i < 16; i++) pat_model[i] = '0;
    @(negedge clk); #1;
    reset = 1'b0;
    play(2, 1, 4, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
